// File: rtl/arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr -- round-robin arbiter draining four show-ahead input FIFOs into
// one downstream FIFO, with bounded bursts per queue and back-pressure pause.
//
// Parameters
//   DATA_SIZE  width of every data word (default 12)
//   BURST_LEN  consecutive pops granted to one queue before rotating (1..7)
//
// Ports
//   clk              single clock, all state changes on posedge
//   reset_L          asynchronous active-low reset
//   fifo0..3_data    head word of input FIFO i (valid while non-empty)
//   fifo_empty[3:0]  bit i high when input FIFO i is empty
//   out_almost_full  downstream FIFO at/above its almost-full threshold
//   pop[3:0]         one-hot pop strobe to input FIFO i (combinational)
//   push             registered write strobe to the downstream FIFO
//   data_out         registered word written downstream, qualified by push
//   grant[1:0]       index of the queue owning the grant
//   state[1:0]       FSM state: IDLE=0, ACTIVE=1, PAUSE=2
//   cont0..3[4:0]    per-queue push counters, only with ARB_PKT_COUNT_EN
//
// Optional feature: define ARB_PKT_COUNT_EN to add the cont0..cont3 outputs.
// -----------------------------------------------------------------------------
module arbitro_rr #(
   parameter int DATA_SIZE = 12,
   parameter int BURST_LEN = 2
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic [DATA_SIZE-1:0] fifo0_data,
   input  logic [DATA_SIZE-1:0] fifo1_data,
   input  logic [DATA_SIZE-1:0] fifo2_data,
   input  logic [DATA_SIZE-1:0] fifo3_data,
   input  logic [3:0]           fifo_empty,
   input  logic                 out_almost_full,
   output logic [3:0]           pop,
   output logic                 push,
   output logic [DATA_SIZE-1:0] data_out,
   output logic [1:0]           grant,
   output logic [1:0]           state
`ifdef ARB_PKT_COUNT_EN
   ,
   output logic [4:0]           cont0,
   output logic [4:0]           cont1,
   output logic [4:0]           cont2,
   output logic [4:0]           cont3
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_PAUSE  = 2'd2;

   localparam logic [2:0] BURST_LAST = 3'(BURST_LEN - 1);

   logic [2:0]           burst_cnt;
   logic [1:0]           rr_ptr;
   logic [1:0]           state_nxt;
   logic [1:0]           grant_nxt;
   logic [2:0]           cnt_nxt;
   logic [1:0]           ptr_nxt;
   logic                 pop_any;
   logic [DATA_SIZE-1:0] head_data;
   logic                 start_hit;
   logic [1:0]           start_idx;
   logic                 next_hit;
   logic [1:0]           next_idx;

   // First non-empty queue scanning start, start+1, ... (mod 4); {found, index}.
   // The scan runs from the far end back so the nearest hit overwrites.
   function automatic logic [2:0] find_from(input logic [1:0] start,
                                            input logic [3:0] empty);
      logic [1:0] idx;
      find_from = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (!empty[idx]) find_from = {1'b1, idx};
      end
   endfunction

   // Scan from the saved pointer when leaving IDLE, and from grant+1 when
   // rotating. The grant+1 scan wraps back onto the granted queue itself as
   // its last candidate, so a lone busy queue keeps the grant after a burst.
   assign {start_hit, start_idx} = find_from(rr_ptr, fifo_empty);
   assign {next_hit,  next_idx}  = find_from(grant + 2'd1, fifo_empty);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      pop = 4'b0000;
      if (state == ST_ACTIVE && !fifo_empty[grant] && !out_almost_full)
         pop[grant] = 1'b1;
   end

   assign pop_any = |pop;

   always_comb begin
      head_data = fifo0_data;
      case (grant)
         2'd0: head_data = fifo0_data;
         2'd1: head_data = fifo1_data;
         2'd2: head_data = fifo2_data;
         2'd3: head_data = fifo3_data;
         default: head_data = fifo0_data;
      endcase
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      cnt_nxt   = burst_cnt;
      ptr_nxt   = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (start_hit) begin
               state_nxt = ST_ACTIVE;
               grant_nxt = start_idx;
               cnt_nxt   = 3'd0;
            end
         end
         ST_ACTIVE: begin
            // Back-pressure wins over everything, including all-empty.
            if (out_almost_full) begin
               state_nxt = ST_PAUSE;
            end else if (pop_any) begin
               if (burst_cnt == BURST_LAST) begin
                  grant_nxt = next_idx;
                  cnt_nxt   = 3'd0;
               end else begin
                  cnt_nxt = burst_cnt + 3'd1;
               end
            end else if (next_hit) begin
               // Granted queue ran dry; hand over to the next busy queue.
               grant_nxt = next_idx;
               cnt_nxt   = 3'd0;
            end else begin
               // Everything empty: park, and resume after this queue later.
               state_nxt = ST_IDLE;
               ptr_nxt   = grant + 2'd1;
               cnt_nxt   = 3'd0;
            end
         end
         ST_PAUSE: begin
            if (!out_almost_full) state_nxt = ST_ACTIVE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ST_IDLE;
         grant     <= 2'd0;
         burst_cnt <= 3'd0;
         rr_ptr    <= 2'd0;
         push      <= 1'b0;
         data_out  <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         burst_cnt <= cnt_nxt;
         rr_ptr    <= ptr_nxt;
         push      <= pop_any;
         if (pop_any) data_out <= head_data;
      end
   end

`ifdef ARB_PKT_COUNT_EN
   // Source queue of the push in flight; counters advance when it lands.
   logic [1:0] push_src;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         push_src <= 2'd0;
         cont0    <= 5'd0;
         cont1    <= 5'd0;
         cont2    <= 5'd0;
         cont3    <= 5'd0;
      end else begin
         if (pop_any) push_src <= grant;
         if (push) begin
            case (push_src)
               2'd0: cont0 <= cont0 + 5'd1;
               2'd1: cont1 <= cont1 + 5'd1;
               2'd2: cont2 <= cont2 + 5'd1;
               2'd3: cont3 <= cont3 + 5'd1;
               default: cont0 <= cont0;
            endcase
         end
      end
   end
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_rr -- self-checking bench for arbitro_rr. Four FIFOs are modelled
// as queues; a behavioural model of the arbitration rules predicts every
// output each cycle, and directed scenarios check push order and grant order.
// -----------------------------------------------------------------------------
module tb_arbitro_rr;

   localparam int DW = 12;
   localparam int BL = 2;

   logic          clk = 1'b0;
   logic          reset_L;
   logic [DW-1:0] fifo0_data, fifo1_data, fifo2_data, fifo3_data;
   logic [3:0]    fifo_empty;
   logic          out_almost_full;
   logic [3:0]    pop;
   logic          push;
   logic [DW-1:0] data_out;
   logic [1:0]    grant;
   logic [1:0]    state;
`ifdef ARB_PKT_COUNT_EN
   logic [4:0]    cont0, cont1, cont2, cont3;
`endif

   arbitro_rr #(.DATA_SIZE(DW), .BURST_LEN(BL)) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .fifo0_data      (fifo0_data),
      .fifo1_data      (fifo1_data),
      .fifo2_data      (fifo2_data),
      .fifo3_data      (fifo3_data),
      .fifo_empty      (fifo_empty),
      .out_almost_full (out_almost_full),
      .pop             (pop),
      .push            (push),
      .data_out        (data_out),
      .grant           (grant),
      .state           (state)
`ifdef ARB_PKT_COUNT_EN
      ,
      .cont0           (cont0),
      .cont1           (cont1),
      .cont2           (cont2),
      .cont3           (cont3)
`endif
   );

   always #5 clk = ~clk;

   // Input FIFO contents, head at index 0.
   logic [DW-1:0] fq [4][$];

   // Reference model: state 0/1/2 = idle/active/pause.
   int            m_state, m_grant, m_cnt, m_ptr;
   logic          m_push;
   logic [DW-1:0] m_data;

   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   logic          afull_drive = 1'b0;

   logic [DW-1:0] pushed [$];
   int            gseq   [$];

   function automatic logic [DW-1:0] head(int i);
      return (fq[i].size() > 0) ? fq[i][0] : '0;
   endfunction

   // First non-empty queue among from, from+1, ... (span entries), or -1.
   function automatic int first_nonempty(int from, int span);
      for (int k = 0; k < span; k++)
         if (fq[(from + k) % 4].size() > 0) return (from + k) % 4;
      return -1;
   endfunction

   function automatic bit all_empty();
      return fq[0].size() == 0 && fq[1].size() == 0 &&
             fq[2].size() == 0 && fq[3].size() == 0;
   endfunction

   task automatic drive_inputs();
      fifo0_data = head(0);
      fifo1_data = head(1);
      fifo2_data = head(2);
      fifo3_data = head(3);
      for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
      out_almost_full = afull_drive;
   endtask

   task automatic model_reset();
      m_state = 0; m_grant = 0; m_cnt = 0; m_ptr = 0;
      m_push  = 1'b0; m_data = '0;
   endtask

   // One clock cycle: called just after a posedge. Drives inputs, checks all
   // outputs against the model at the falling edge, then advances the model.
   task automatic step();
      int            n_state, n_grant, n_cnt, n_ptr, nx;
      logic          popping;
      logic [3:0]    exp_pop;
      logic [DW-1:0] popped;
      drive_inputs();
      @(negedge clk);
      cyc++;
      popping = (m_state == 1) && (fq[m_grant].size() > 0) && !afull_drive;
      exp_pop = popping ? 4'(1 << m_grant) : 4'b0000;

      vectors++;
      if (pop !== exp_pop) begin
         miscompares++;
         $display("FAIL pop cyc=%0d got=%b exp=%b", cyc, pop, exp_pop);
      end
      vectors++;
      if (push !== m_push) begin
         miscompares++;
         $display("FAIL push cyc=%0d got=%b exp=%b", cyc, push, m_push);
      end
      vectors++;
      if (data_out !== m_data) begin
         miscompares++;
         $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, data_out, m_data);
      end
      vectors++;
      if (grant !== 2'(m_grant)) begin
         miscompares++;
         $display("FAIL grant cyc=%0d got=%0d exp=%0d", cyc, grant, m_grant);
      end
      vectors++;
      if (state !== 2'(m_state)) begin
         miscompares++;
         $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, m_state);
      end

      n_state = m_state; n_grant = m_grant; n_cnt = m_cnt; n_ptr = m_ptr;
      case (m_state)
         0: begin
            nx = first_nonempty(m_ptr, 4);
            if (nx >= 0) begin n_state = 1; n_grant = nx; n_cnt = 0; end
         end
         1: begin
            if (afull_drive) n_state = 2;
            else if (popping) begin
               if (m_cnt + 1 == BL) begin
                  n_grant = first_nonempty(m_grant + 1, 4);
                  n_cnt   = 0;
               end else n_cnt = m_cnt + 1;
            end else begin
               nx = first_nonempty(m_grant + 1, 3);
               if (nx >= 0) begin n_grant = nx; n_cnt = 0; end
               else begin n_state = 0; n_ptr = (m_grant + 1) % 4; n_cnt = 0; end
            end
         end
         default: if (!afull_drive) n_state = 1;
      endcase

      popped = head(m_grant);
      @(posedge clk);
      #1;
      if (popping) begin
         m_data = popped;
         void'(fq[m_grant].pop_front());
      end
      m_push = popping;
      m_state = n_state; m_grant = n_grant; m_cnt = n_cnt; m_ptr = n_ptr;

      if (push === 1'b1) pushed.push_back(data_out);
      if (state === 2'd1 && (gseq.size() == 0 || gseq[$] != int'(grant)))
         gseq.push_back(int'(grant));
   endtask

   task automatic run_until_idle(int budget, string name);
      int n = 0;
      while (!(m_state == 0 && all_empty()) && n < budget) begin
         step();
         n++;
      end
      step();
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL %s timeout after %0d cycles, state=%0d", name, n, m_state);
      end
   endtask

   task automatic compare_pushes(string name, logic [DW-1:0] exp_list [$]);
      vectors++;
      if (pushed.size() != exp_list.size()) begin
         miscompares++;
         $display("FAIL %s push count got=%0d exp=%0d", name, pushed.size(), exp_list.size());
      end else begin
         for (int i = 0; i < exp_list.size(); i++) begin
            vectors++;
            if (pushed[i] !== exp_list[i]) begin
               miscompares++;
               $display("FAIL %s push[%0d] got=%h exp=%h", name, i, pushed[i], exp_list[i]);
            end
         end
      end
   endtask

   task automatic compare_grants(string name, int exp_list [$]);
      vectors++;
      if (gseq.size() != exp_list.size()) begin
         miscompares++;
         $display("FAIL %s grant seq length got=%0d exp=%0d", name, gseq.size(), exp_list.size());
      end else begin
         for (int i = 0; i < exp_list.size(); i++) begin
            vectors++;
            if (gseq[i] != exp_list[i]) begin
               miscompares++;
               $display("FAIL %s grant[%0d] got=%0d exp=%0d", name, i, gseq[i], exp_list[i]);
            end
         end
      end
   endtask

   task automatic hard_reset();
      reset_L = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      afull_drive = 1'b0;
      drive_inputs();
      hard_reset();
      vectors++;
      if ({pop, push, data_out, grant, state} !== '0) begin
         miscompares++;
         $display("FAIL reset_values pop=%b push=%b data_out=%h grant=%0d state=%0d exp all zero",
                  pop, push, data_out, grant, state);
      end
      step();
   endtask

   task automatic test_two_queues();
      logic [DW-1:0] exp_d [$] = '{12'h010, 12'h011, 12'h810, 12'h811, 12'h012, 12'h812};
      int            exp_g [$] = '{0, 2, 0, 2};
      pushed.delete(); gseq.delete();
      for (int i = 0; i < 3; i++) begin
         fq[0].push_back(12'h010 + 12'(i));
         fq[2].push_back(12'h810 + 12'(i));
      end
      run_until_idle(60, "two_queues");
      compare_pushes("two_queues", exp_d);
      compare_grants("two_queues", exp_g);
   endtask

   task automatic test_single_queue();
      logic [DW-1:0] exp_d [$] = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304};
      int            exp_g [$] = '{3};
      int            run = 0;
      int            best = 0;
      pushed.delete(); gseq.delete();
      for (int i = 0; i < 5; i++) fq[3].push_back(12'h300 + 12'(i));
      for (int n = 0; n < 40 && !(m_state == 0 && all_empty()); n++) begin
         step();
         run  = (push === 1'b1) ? run + 1 : 0;
         best = (run > best) ? run : best;
      end
      run_until_idle(10, "single_queue");
      compare_pushes("single_queue", exp_d);
      compare_grants("single_queue", exp_g);
      vectors++;
      if (best != 5) begin
         miscompares++;
         $display("FAIL single_queue consecutive pushes got=%0d exp=5", best);
      end
   endtask

   task automatic test_pause();
      logic [DW-1:0] exp_d [$] = '{12'h100, 12'h101, 12'h200, 12'h102};
      int            n = 0;
      pushed.delete(); gseq.delete();
      for (int i = 0; i < 3; i++) fq[1].push_back(12'h100 + 12'(i));
      fq[2].push_back(12'h200);
      while (pushed.size() == 0 && n < 10) begin step(); n++; end
      // First pop landed at the last edge; throttle now.
      afull_drive = 1'b1;
      step();
      step();
      vectors++;
      if (state !== 2'd2 || pop !== 4'b0000 || push !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_hold state=%0d pop=%b push=%b exp state=2 pop=0000 push=0",
                  state, pop, push);
      end
      step();
      afull_drive = 1'b0;
      run_until_idle(40, "pause");
      compare_pushes("pause", exp_d);
   endtask

   task automatic test_wrap();
      logic [DW-1:0] exp_d [$] = '{12'h3a0, 12'h3a1, 12'h0a0};
      int            exp_g [$] = '{3, 0};
      pushed.delete(); gseq.delete();
      fq[3].push_back(12'h3a0);
      fq[3].push_back(12'h3a1);
      step();
      step();
      fq[0].push_back(12'h0a0);
      run_until_idle(30, "wrap");
      compare_pushes("wrap", exp_d);
      compare_grants("wrap", exp_g);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      for (int i = 0; i < 4; i++) fq[2].push_back(12'h5c0 + 12'(i));
      for (int i = 0; i < 3; i++) fq[0].push_back(12'h4b0 + 12'(i));
      repeat (3) step();
      reset_L = 1'b0;
      #1;
      vectors++;
      if ({pop, push, data_out, grant, state} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_immediate pop=%b push=%b data_out=%h grant=%0d state=%0d exp all zero",
                  pop, push, data_out, grant, state);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({pop, push, data_out, grant, state} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_held pop=%b push=%b data_out=%h grant=%0d state=%0d exp all zero",
                  pop, push, data_out, grant, state);
      end
      reset_L = 1'b1;
      while (state !== 2'd1 && n < 5) begin step(); n++; end
      vectors++;
      if (state !== 2'd1 || grant !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_mid_first_grant state=%0d grant=%0d exp state=1 grant=0", state, grant);
      end
      run_until_idle(60, "reset_mid");
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            int q = int'($urandom_range(0, 3));
            if (fq[q].size() < 6) fq[q].push_back(DW'($urandom));
         end
         afull_drive = ($urandom_range(0, 4) == 0);
         step();
      end
      afull_drive = 1'b0;
      run_until_idle(200, "random");
   endtask

`ifdef ARB_PKT_COUNT_EN
   task automatic test_pkt_count();
      hard_reset();
      for (int i = 0; i < 33; i++) fq[1].push_back(DW'(i));
      run_until_idle(120, "pkt_count");
      vectors++;
      if (cont0 !== 5'd0 || cont1 !== 5'd1 || cont2 !== 5'd0 || cont3 !== 5'd0) begin
         miscompares++;
         $display("FAIL pkt_count got=%0d/%0d/%0d/%0d exp=0/1/0/0", cont0, cont1, cont2, cont3);
      end
   endtask
`endif

   initial begin
      reset_L = 1'b0;
      model_reset();
      test_reset();
      test_two_queues();
      test_single_queue();
      test_pause();
      test_wrap();
      test_reset_mid();
      test_random();
`ifdef ARB_PKT_COUNT_EN
      test_pkt_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
